// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo up/down counter: direction encodings
// and the prescaler width helpers.
package mod_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Prescaler phase register width; never narrower than one bit.
    function automatic int presc_width(input int prescale);
        return (clog2(prescale) < 1) ? 1 : clog2(prescale);
    endfunction

endpackage

// File: rtl/mod_counter_tick_gen.sv
// Prescaler for mod_counter: counts enabled cycles and flags the edge on
// which a count step must happen. Phase is held while enable is low and
// restarted from zero by restart (clear or load in the parent).
module tick_gen
    import mod_counter_pkg::*;
#(
    parameter int PRESCALE = 1
)(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int            PW   = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_reg;
    logic [PW-1:0] presc_next;

    // Step request: last phase of the period reached on an enabled edge.
    // Decoded from the registered phase, so it is stable across the cycle.
    assign tick = enable && !restart && (presc_reg == LAST);

    // Next phase: restart wins, otherwise advance and wrap only while enabled.
    always_comb begin
        presc_next = presc_reg;
        if (restart) begin
            presc_next = '0;
        end else if (enable) begin
            presc_next = (presc_reg == LAST) ? '0 : presc_reg + 1'b1;
        end
    end

    // Phase register, cleared asynchronously so a reset aborts mid-prescale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with prescaler, synchronous clear/load
// and a one-cycle terminal-count pulse.
// Build option: MOD_COUNTER_SATURATE_EN -- when defined the count saturates
// at the range ends instead of wrapping (tc still pulses on a blocked step).
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int PRESCALE = 1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             step
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);

`ifdef MOD_COUNTER_SATURATE_EN
    localparam logic SATURATE = 1'b1;
`else
    localparam logic SATURATE = 1'b0;
`endif

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             tc_reg;
    logic             tc_next;
    logic             step_reg;
    logic             step_next;
    logic             tick;
    logic             restart;

    // Clear and load both restart the prescale period.
    assign restart = clear | load;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .restart (restart),
        .tick    (tick)
    );

    // Next count: clear > load > step; tc and step only follow a stepping edge.
    always_comb begin
        count_next = count_reg;
        tc_next    = 1'b0;
        step_next  = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next = (load_val > MAX_CNT) ? MAX_CNT : load_val;
        end else if (tick) begin
            step_next = 1'b1;
            case (up_dn)
                DIR_UP: begin
                    if (count_reg == MAX_CNT) begin
                        tc_next    = 1'b1;
                        count_next = SATURATE ? count_reg : '0;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
                DIR_DOWN: begin
                    if (count_reg == '0) begin
                        tc_next    = 1'b1;
                        count_next = SATURATE ? count_reg : MAX_CNT;
                    end else begin
                        count_next = count_reg - 1'b1;
                    end
                end
                default: begin
                    count_next = count_reg;
                end
            endcase
        end
    end

    // Output registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
            step_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
            step_reg  <= step_next;
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;
    assign step  = step_reg;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: two instances (PRESCALE=1 and 3, both
// WIDTH=4, MODULO=10) share one input stream. Expected outputs come from an
// arithmetic reference model and are queued per instance; a monitor pops
// and compares after every clock edge and after an asynchronous reset drop.
module tb_mod_counter;

    localparam int M = 10;
`ifdef MOD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] count;
        logic       tc;
        logic       step;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, ud, clr, ld;
    logic [3:0] lv;
    logic [3:0] count1, count3;
    logic       tc1, tc3, step1, step3;

    exp_t q1[$];
    exp_t q3[$];
    int   m1_cnt, m1_pre, m3_cnt, m3_pre;
    int   n_tests = 0;
    int   n_fail  = 0;
    event mon_ev;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MODULO(M), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .enable(en), .up_dn(ud), .clear(clr),
        .load(ld), .load_val(lv), .count(count1), .tc(tc1), .step(step1)
    );

    mod_counter #(.WIDTH(4), .MODULO(M), .PRESCALE(3)) dut3 (
        .clk(clk), .reset(reset), .enable(en), .up_dn(ud), .clear(clr),
        .load(ld), .load_val(lv), .count(count3), .tc(tc3), .step(step3)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference behaviour of one clock edge, from the counting rules.
    task automatic model_edge(input int p, inout int cnt, inout int pre,
                              input logic r, e, u, c, l, input logic [3:0] v,
                              output exp_t res);
        int nxt;
        res = '0;
        if (!r) begin
            cnt = 0;
            pre = 0;
        end else if (c) begin
            cnt = 0;
            pre = 0;
        end else if (l) begin
            cnt = (int'(v) > M - 1) ? M - 1 : int'(v);
            pre = 0;
        end else if (e) begin
            pre = pre + 1;
            if (pre == p) begin
                pre      = 0;
                res.step = 1'b1;
                nxt      = u ? cnt + 1 : cnt - 1;
                if (nxt < 0 || nxt >= M) begin
                    res.tc = 1'b1;
                    if (!SAT) cnt = (nxt + M) % M;
                end else begin
                    cnt = nxt;
                end
            end
        end
        res.count = 4'(cnt);
    endtask

    // Apply inputs for the coming rising edge and queue its expected outcome.
    task automatic drive(input logic r, e, u, c, l, input logic [3:0] v);
        exp_t x1, x3;
        reset = r; en = e; ud = u; clr = c; ld = l; lv = v;
        model_edge(1, m1_cnt, m1_pre, r, e, u, c, l, v, x1);
        model_edge(3, m3_cnt, m3_pre, r, e, u, c, l, v, x3);
        q1.push_back(x1);
        q3.push_back(x3);
        $display("[TB] t=%0t rst=%b en=%b up=%b clr=%b ld=%b lv=%0d -> exp1=%0d/%b/%b exp3=%0d/%b/%b",
                 $time, r, e, u, c, l, v, x1.count, x1.tc, x1.step, x3.count, x3.tc, x3.step);
    endtask

    task automatic cyc(input logic e, u, c, l, input logic [3:0] v);
        @(negedge clk);
        drive(1'b1, e, u, c, l, v);
    endtask

    // Monitor: compare after each edge (or asynchronous reset drop).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or mon_ev);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("p1 count", 8'(count1), 8'(e.count));
                check("p1 tc",    8'(tc1),    8'(e.tc));
                check("p1 step",  8'(step1),  8'(e.step));
            end
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check("p3 count", 8'(count3), 8'(e.count));
                check("p3 tc",    8'(tc3),    8'(e.tc));
                check("p3 step",  8'(step3),  8'(e.step));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t z;
        z = '0;
        m1_cnt = 0; m1_pre = 0; m3_cnt = 0; m3_pre = 0;
        // Reset held low for three edges.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        end
        // Count up through the wrap.
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        // Count down through zero.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        // Clear beats load; out-of-range load clamps.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd13);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd13);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        // Enable dropped mid-prescale keeps the phase.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        // Load 6, step once to 7, then pulse reset between edges.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd6);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        #1;
        q1.push_back(z);
        q3.push_back(z);
        m1_cnt = 0; m1_pre = 0; m3_cnt = 0; m3_pre = 0;
        reset = 1'b0;
        $display("[TB] t=%0t async reset asserted", $time);
        -> mon_ev;
        #2;
        reset = 1'b1;
        #1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0,
                4'($urandom_range(0, 15)));
        end
        @(posedge clk);
        #3;
        check("p1 queue drained", 8'(q1.size()), 8'd0);
        check("p3 queue drained", 8'(q3.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
